alu_cmd_queue: RTL
==================

Name: alu_cmd_queue

Overview:
- Command buffer and issue sequencer that sits directly upstream of the ALU.
- Accepts {op, A, B} commands over a valid/ready interface and buffers them in a FIFO.
- Issues each command to the ALU using its start/done protocol and returns results in order over a valid/ready response port.
- A watchdog aborts any ALU operation whose done never arrives.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 16, maximum cycles alu_start may stay high without alu_done before the command is aborted.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept; equals rst_n && (count < DEPTH).
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101/110/111 are illegal.
- alu_a  out  8  operand A to the ALU.
- alu_b  out  8  operand B to the ALU.
- alu_op  out  3  opcode to the ALU.
- alu_start  out  1  ALU start.
- alu_done  in  1  ALU done.
- alu_result  in  16  ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  16  result.
- rsp_op  out  3  opcode of the responding command.
- rsp_err  out  1  1 = command timed out.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - FIFO emptied, count=0, state IDLE, watchdog cleared.
  - alu_start=0, alu_a=alu_b=0, alu_op=0.
  - rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0.
  - An in-flight ALU command is abandoned; no response is produced for it.
- FIFO:
  - 19-bit entries {op, a, b}; circular read/write pointers wrap at DEPTH.
  - Push on cmd_valid && cmd_ready; pop only in IDLE when count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle (no bypass).
- FSM states: IDLE, ISSUE, NOP, RESP.
- IDLE, count > 0: pop the head and register alu_a/alu_b/alu_op from it.
  - Legal op other than 000: alu_start=1 from this edge; go to ISSUE; watchdog=0.
  - op 000: alu_start=1 for exactly one cycle; go to NOP.
  - Illegal op: entry discarded, alu_start stays 0, no response, stay IDLE.
- NOP: alu_start=0; go to IDLE. No response is produced and alu_done is ignored.
- ISSUE: alu_start, alu_a, alu_b, alu_op held stable; watchdog increments each cycle.
  - alu_done sampled 1: capture rsp_result=alu_result, rsp_op=alu_op, rsp_err=0; alu_start=0; rsp_valid=1; go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: alu_start=0; rsp_result=16'h0000, rsp_err=1, rsp_valid=1; go to RESP.
  - alu_done in the same cycle as the timeout edge: done wins, rsp_err=0.
- RESP: rsp_* held stable until rsp_valid && rsp_ready, then rsp_valid=0 and go to IDLE.
  - alu_done while not in ISSUE is ignored.
- Start spacing: alu_start is low for at least one cycle between consecutive commands.
- Latency: a command pushed at edge N into an empty, idle queue raises alu_start at edge N+1.
  - rsp_valid rises one edge after alu_done is sampled.
- Ordering: responses follow acceptance order. No_op and illegal commands produce no response.
- Backpressure: rsp_ready=0 stalls the FSM in RESP; the FIFO still accepts commands until full.

Test Plan:
- Push add A=10 B=20; ALU model asserts done one cycle after start -> alu_start high from edge N+1 with alu_op=001; then rsp_valid=1, rsp_result=16'd30, rsp_op=001, rsp_err=0.
- rsp_ready=0; push 5 mul commands (2×3, 4×5, 6×7, 8×9, 10×11) -> cmd_ready=0 once the queue is full, remaining commands accepted only as space frees; after releasing rsp_ready, results 6, 20, 42, 72, 110 arrive in order.
- Push no_op, then xor F0^0F -> one-cycle alu_start with op 000 and no response; then xor issued with start low in between; rsp_result=16'h00FF.
- Push op 111 then and FF&0F -> 111 popped with no alu_start and no response; rsp_result=16'h000F.
- Push add; hold alu_done=0 -> alu_start drops after 16 cycles; rsp_valid=1, rsp_err=1, rsp_result=0; the next command then issues normally.
- Assert rst_n=0 mid-ISSUE with 2 commands queued -> alu_start=0, count=0, rsp_valid=0 immediately; after release, no stale response and cmd_ready=1.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// Command FIFO and issue sequencer in front of the ALU: buffers {op, a, b}, runs the
// start/done handshake with a watchdog, and returns results in order on a valid/ready port.
module alu_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_a,
  input  logic [7:0]                   cmd_b,
  input  logic [2:0]                   cmd_op,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic [2:0]                   alu_op,
  output logic                         alu_start,
  input  logic                         alu_done,
  input  logic [15:0]                  alu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_result,
  output logic [2:0]                   rsp_op,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, NOP, RESP} state_t;

  state_t            state, state_nx;
  logic [18:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [WD_W-1:0]   wdog, wdog_nx;
  logic [18:0]       head;
  logic              push, pop;

  logic              start_nx, rsp_valid_nx, rsp_err_nx;
  logic [7:0]        alu_a_nx, alu_b_nx;
  logic [2:0]        alu_op_nx, rsp_op_nx;
  logic [15:0]       rsp_result_nx;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

  // A full queue refuses even when a pop happens the same cycle
  assign cmd_ready = rst_n & (count < CNT_W'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_comb begin
    state_nx      = state;
    start_nx      = alu_start;
    alu_a_nx      = alu_a;
    alu_b_nx      = alu_b;
    alu_op_nx     = alu_op;
    wdog_nx       = wdog;
    rsp_valid_nx  = rsp_valid;
    rsp_result_nx = rsp_result;
    rsp_op_nx     = rsp_op;
    rsp_err_nx    = rsp_err;
    case (state)
      IDLE: begin
        if (count != '0) begin
          alu_op_nx = head[18:16];
          alu_a_nx  = head[15:8];
          alu_b_nx  = head[7:0];
          if (head[18:16] == 3'b000) begin
            start_nx = 1'b1;
            state_nx = NOP;
          end else if (op_legal(head[18:16])) begin
            start_nx = 1'b1;
            wdog_nx  = '0;
            state_nx = ISSUE;
          end
        end
      end
      NOP: begin
        start_nx = 1'b0;
        state_nx = IDLE;
      end
      ISSUE: begin
        // done takes priority over a timeout landing on the same edge
        if (alu_done) begin
          rsp_result_nx = alu_result;
          rsp_op_nx     = alu_op;
          rsp_err_nx    = 1'b0;
          rsp_valid_nx  = 1'b1;
          start_nx      = 1'b0;
          state_nx      = RESP;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          rsp_result_nx = 16'h0000;
          rsp_op_nx     = alu_op;
          rsp_err_nx    = 1'b1;
          rsp_valid_nx  = 1'b1;
          start_nx      = 1'b0;
          state_nx      = RESP;
        end else begin
          wdog_nx = wdog + WD_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wdog       <= '0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      wdog       <= wdog_nx;
      alu_start  <= start_nx;
      alu_a      <= alu_a_nx;
      alu_b      <= alu_b_nx;
      alu_op     <= alu_op_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_result <= rsp_result_nx;
      rsp_op     <= rsp_op_nx;
      rsp_err    <= rsp_err_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

endmodule
